mem_request_arbiter: RTL and testbench
======================================

// Module: mem_request_arbiter
// PURPOSE
// Sits directly downstream of request_unit: merges its imemREN and dmemREN/dmemWEN requests onto
// the single-ported RAM and returns one-cycle ihit/dhit pulses plus load data. FSM-based; latches
// each granted request, waits out RAM latency, retries on ERROR. Data wins ties, with an I-starvation guard.
// PARAMETERS
// MAX_RETRY     3   ERROR retries per transaction before abort + sticky arb_error
// STARVE_LIMIT  4   consecutive D grants with imemREN pending before I is forced
// PORTS
// CLK         in   1   system clock, rising edge
// nRST        in   1   asynchronous active-low reset
// imemREN     in   1   instruction fetch request (held until ihit)
// imemaddr    in   32  fetch address
// imemload    out  32  fetched instruction, valid when ihit=1
// ihit        out  1   one-cycle fetch completion pulse
// dmemREN     in   1   data read request (held until dhit)
// dmemWEN     in   1   data write request (held until dhit)
// dmemaddr    in   32  data address
// dmemstore   in   32  write data
// dmemload    out  32  read data, valid when dhit=1
// dhit        out  1   one-cycle data completion pulse
// ramREN      out  1   RAM read strobe
// ramWEN      out  1   RAM write strobe
// ramaddr     out  32  RAM address
// ramstore    out  32  RAM write data
// ramload     in   32  RAM read data, valid when ramstate==ACCESS
// ramstate    in   2   ramstate_t: FREE, BUSY, ACCESS, ERROR
// arb_error   out  1   sticky: a transaction exhausted MAX_RETRY
// BEHAVIOUR
// - Reset (async): state=IDLE, all outputs 0, retry/starve counters 0, arb_error=0, latches 0.
// - States: IDLE, IACC, DACC, RETRY, RESP.
// - IDLE grant: dmemREN|dmemWEN -> DACC, unless imemREN && starve_cnt==STARVE_LIMIT -> IACC;
//   else imemREN -> IACC. On grant latch addr, store data, we=dmemWEN, src(I/D). dmemWEN wins over
//   dmemREN if both set. starve_cnt: +1 per D grant with imemREN high, cleared on I grant, saturates.
// - IACC/DACC: ramREN=~we, ramWEN=we, ramaddr/ramstore from latches (never from live inputs).
//   ramstate==ACCESS -> capture ramload into load reg, go RESP. BUSY/FREE -> stay.
//   ramstate==ERROR -> RETRY (strobes 0 for one cycle), retry_cnt+1, back to same ACC state.
//   retry_cnt==MAX_RETRY on ERROR -> set arb_error, IDLE, no hit; requester reissues.
// - RESP: exactly one cycle; ihit (src=I) or dhit (src=D) =1, imemload/dmemload = load reg;
//   retry_cnt cleared; -> IDLE. Minimum request-to-hit latency 3 cycles (IDLE, ACC w/ ACCESS, RESP).
// - Load outputs hold last value between hits; ihit and dhit never high together.
// - Cancel: read whose REN drops before ACCESS -> abort to IDLE next edge, no hit, no capture.
//   Writes are never cancelled: complete to RAM, dhit suppressed if dmemWEN already dropped.
// - Address or data change while granted: ignored until next grant (latched).
// - Reset mid-transaction: strobes drop asynchronously; no hit issued; arb_error cleared.
// STRUCTURE
// - cpu_types_pkg: word_t, ramstate_t (existing); add arb_state_t enum and src_t (I/D).
// - Single module; FSM, latches, counters inline. No sub-module needed.
// TESTING
// 1 I only: imemREN=1, imemaddr=0x40, RAM ACCESS after 2 BUSY, ramload=0x2402000A
//   -> ramREN=1 ramaddr=0x40, ihit one cycle after ACCESS, imemload=0x2402000A.
// 2 Tie: imemREN & dmemREN @0x100 same cycle -> D served first (dhit), then I (ihit); never both.
// 3 Write: dmemWEN=1, addr 0x200, store 0xDEADBEEF -> ramWEN=1 ramstore=0xDEADBEEF, dhit=1,
//   dmemload unchanged.
// 4 Starvation: imemREN held, 5 back-to-back D reads, STARVE_LIMIT=4 -> 5th grant goes to I.
// 5 Errors: ERROR x2 then ACCESS -> 2 RETRY cycles, strobes low in each, hit delivered,
//   arb_error=0; ERROR x4 -> arb_error=1, no hit, returns IDLE.
// 6 Reset/cancel: nRST low mid-DACC -> ramREN/ramWEN 0 same cycle; dmemREN dropped in BUSY
//   -> IDLE, no dhit; dmemWEN dropped in BUSY -> RAM write completes, no dhit.

Source files
------------

// File: rtl/mem_request_arbiter_pkg.sv
// Shared types for the memory request arbiter: RAM status codes,
// arbiter FSM states, requester identity and counter sizing helper.
package mem_request_arbiter_pkg;

   typedef logic [31:0] word_t;

   // Status reported by the single-ported RAM every cycle.
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   // Arbiter FSM states.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_IACC  = 3'd1,
      ST_DACC  = 3'd2,
      ST_RETRY = 3'd3,
      ST_RESP  = 3'd4
   } arb_state_t;

   // Which requester owns the transaction currently in flight.
   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } src_t;

   localparam int DEF_MAX_RETRY    = 3;
   localparam int DEF_STARVE_LIMIT = 4;

   // Bits needed for a counter that must reach max_val inclusive.
   function automatic int cnt_width(input int max_val);
      if (max_val < 2) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_request_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the arbiter.
// slave  : the arbiter's view (takes requests and RAM status, drives hits/strobes)
// master : the environment's view (requesters plus RAM)
interface mem_request_arbiter_if;
   import mem_request_arbiter_pkg::*;

   // instruction fetch side
   logic      imemREN;
   word_t     imemaddr;
   word_t     imemload;
   logic      ihit;

   // data side
   logic      dmemREN;
   logic      dmemWEN;
   word_t     dmemaddr;
   word_t     dmemstore;
   word_t     dmemload;
   logic      dhit;

   // RAM side
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   // sticky retry-exhaustion flag
   logic      arb_error;

   modport slave (
      input  imemREN, imemaddr,
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  ramload, ramstate,
      output imemload, ihit,
      output dmemload, dhit,
      output ramREN, ramWEN, ramaddr, ramstore,
      output arb_error
   );

   modport master (
      output imemREN, imemaddr,
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      output ramload, ramstate,
      input  imemload, ihit,
      input  dmemload, dhit,
      input  ramREN, ramWEN, ramaddr, ramstore,
      input  arb_error
   );

endinterface

// File: rtl/mem_request_arbiter.sv
// Merges instruction fetches and data reads/writes onto one single-ported
// RAM. Each granted request is latched, RAM latency is waited out, ERROR
// responses are retried a bounded number of times, and a one-cycle ihit or
// dhit is returned with the load data. Data wins ties unless the fetch
// side has been passed over STARVE_LIMIT times in a row.
module mem_request_arbiter
   import mem_request_arbiter_pkg::*;
#(
   parameter int MAX_RETRY    = DEF_MAX_RETRY,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                 CLK,
   input  logic                 nRST,
   mem_request_arbiter_if.slave bus
);

   localparam int RW = cnt_width(MAX_RETRY);
   localparam int SW = cnt_width(STARVE_LIMIT);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   // FSM state and transaction latches
   arb_state_t    r_state;
   src_t          r_src;
   logic          r_we;
   word_t         r_addr;
   word_t         r_store;

   // registered outputs
   logic          r_ram_ren;
   logic          r_ram_wen;
   logic          r_ihit;
   logic          r_dhit;
   word_t         r_imemload;
   word_t         r_dmemload;
   logic          r_arb_error;

   // counters
   logic [RW-1:0] r_retry_cnt;
   logic [SW-1:0] r_starve_cnt;

   // request decode
   logic          w_d_req;
   logic          w_i_req;
   logic          w_i_forced;
   logic          w_live_ren;
   logic          w_cancel;

   assign w_d_req    = bus.dmemREN | bus.dmemWEN;
   assign w_i_req    = bus.imemREN;
   // fetch side has waited through STARVE_LIMIT data grants: it goes next
   assign w_i_forced = w_i_req && (r_starve_cnt == STARVE_MAX);
   // the owner's read request as it is right now (writes are never withdrawn)
   assign w_live_ren = (r_src == SRC_I) ? bus.imemREN : bus.dmemREN;
   assign w_cancel   = ~r_we & ~w_live_ren;

   // Arbiter FSM: grant, RAM access, retry, one-cycle response; all outputs registered
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state      <= ST_IDLE;
         r_src        <= SRC_I;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_store      <= '0;
         r_ram_ren    <= 1'b0;
         r_ram_wen    <= 1'b0;
         r_ihit       <= 1'b0;
         r_dhit       <= 1'b0;
         r_imemload   <= '0;
         r_dmemload   <= '0;
         r_arb_error  <= 1'b0;
         r_retry_cnt  <= '0;
         r_starve_cnt <= '0;
      end else begin
         // hits are single-cycle pulses unless re-armed below
         r_ihit <= 1'b0;
         r_dhit <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_d_req && !w_i_forced) begin
                  // data grant; a write takes precedence over a read
                  r_state   <= ST_DACC;
                  r_src     <= SRC_D;
                  r_addr    <= bus.dmemaddr;
                  r_store   <= bus.dmemstore;
                  r_we      <= bus.dmemWEN;
                  r_ram_ren <= ~bus.dmemWEN;
                  r_ram_wen <= bus.dmemWEN;
                  if (w_i_req && (r_starve_cnt != STARVE_MAX)) begin
                     r_starve_cnt <= r_starve_cnt + 1'b1;
                  end
               end else if (w_i_req) begin
                  // fetch grant; clears the starvation history
                  r_state      <= ST_IACC;
                  r_src        <= SRC_I;
                  r_addr       <= bus.imemaddr;
                  r_store      <= '0;
                  r_we         <= 1'b0;
                  r_ram_ren    <= 1'b1;
                  r_ram_wen    <= 1'b0;
                  r_starve_cnt <= '0;
               end
            end

            ST_IACC, ST_DACC: begin
               if (w_cancel) begin
                  // read withdrawn before data arrived: drop it silently
                  r_state     <= ST_IDLE;
                  r_ram_ren   <= 1'b0;
                  r_ram_wen   <= 1'b0;
                  r_retry_cnt <= '0;
               end else begin
                  case (bus.ramstate)
                     ACCESS: begin
                        r_state   <= ST_RESP;
                        r_ram_ren <= 1'b0;
                        r_ram_wen <= 1'b0;
                        if (!r_we) begin
                           if (r_src == SRC_I) begin
                              r_imemload <= bus.ramload;
                              r_ihit     <= 1'b1;
                           end else begin
                              r_dmemload <= bus.ramload;
                              r_dhit     <= 1'b1;
                           end
                        end else begin
                           // write reached RAM; acknowledge only a requester still waiting
                           r_dhit <= bus.dmemWEN;
                        end
                     end
                     ERROR: begin
                        r_ram_ren <= 1'b0;
                        r_ram_wen <= 1'b0;
                        if (r_retry_cnt == RETRY_MAX) begin
                           // out of retries: give up, requester will reissue
                           r_arb_error <= 1'b1;
                           r_retry_cnt <= '0;
                           r_state     <= ST_IDLE;
                        end else begin
                           r_retry_cnt <= r_retry_cnt + 1'b1;
                           r_state     <= ST_RETRY;
                        end
                     end
                     BUSY, FREE: begin
                        // RAM still working: keep strobes and latches steady
                     end
                     default: begin
                     end
                  endcase
               end
            end

            ST_RETRY: begin
               if (w_cancel) begin
                  r_state     <= ST_IDLE;
                  r_retry_cnt <= '0;
               end else begin
                  // re-present the latched request after the one-cycle gap
                  r_ram_ren <= ~r_we;
                  r_ram_wen <= r_we;
                  r_state   <= (r_src == SRC_I) ? ST_IACC : ST_DACC;
               end
            end

            ST_RESP: begin
               r_retry_cnt <= '0;
               r_state     <= ST_IDLE;
            end

            default: begin
               r_state   <= ST_IDLE;
               r_ram_ren <= 1'b0;
               r_ram_wen <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ramREN    = r_ram_ren;
   assign bus.ramWEN    = r_ram_wen;
   assign bus.ramaddr   = r_addr;
   assign bus.ramstore  = r_store;
   assign bus.ihit      = r_ihit;
   assign bus.dhit      = r_dhit;
   assign bus.imemload  = r_imemload;
   assign bus.dmemload  = r_dmemload;
   assign bus.arb_error = r_arb_error;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Randomized bench for mem_request_arbiter. Two requesters and a RAM are
// modelled at transaction level: the bench decides grants from the
// priority rules, scripts RAM responses (waits, errors, access) and keeps
// a word memory, then checks strobes, hits, load data and arb_error each cycle.
module tb_mem_request_arbiter;
   import mem_request_arbiter_pkg::*;

   localparam int MAXR = 3;
   localparam int SLIM = 4;
   localparam int NCYC = 3000;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;

   mem_request_arbiter_if bus ();

   mem_request_arbiter #(
      .MAX_RETRY    (MAXR),
      .STARVE_LIMIT (SLIM)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.slave)
   );

   always #5 CLK = ~CLK;

   int    n_vec = 0;
   int    n_bad = 0;
   int    n_txn = 0;
   int    cyc   = 0;

   // memory image shared by both requesters (word addressed, 0x000-0x1FC)
   word_t mem [128];

   // requester state
   bit    i_pend, d_pend, d_we, d_both, d_ghost;
   word_t i_addr, d_addr, d_data;

   // transaction currently owned by the RAM, as the rules predict it
   bit    txn_active;
   src_t  t_src;
   bit    t_we;
   word_t t_addr, t_data;
   int    t_err, t_plan;
   int    resume_cyc, idle_cyc, starve;

   // expected outputs for the cycle about to be sampled
   bit    exp_ihit, exp_dhit, exp_err;
   word_t exp_iload, exp_dload;

   bit    stb;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // One clock cycle: check outputs, update requesters, grant, answer from RAM.
   task automatic step_cycle(input bit hold_busy, output bit strobing);
      bit        nxt_ihit, nxt_dhit, i_quiet, d_quiet, live;
      ramstate_t rs;
      word_t     ld;
      int        idx, r;

      @(negedge CLK);
      strobing = txn_active && (cyc >= resume_cyc);

      check_val("ramREN", 32'(bus.ramREN), 32'(strobing && !t_we));
      check_val("ramWEN", 32'(bus.ramWEN), 32'(strobing && t_we));
      if (strobing) begin
         check_val("ramaddr", bus.ramaddr, t_addr);
         if (t_we) check_val("ramstore", bus.ramstore, t_data);
      end
      check_val("ihit", 32'(bus.ihit), 32'(exp_ihit));
      check_val("dhit", 32'(bus.dhit), 32'(exp_dhit));
      check_val("imemload", bus.imemload, exp_iload);
      check_val("dmemload", bus.dmemload, exp_dload);
      check_val("arb_error", 32'(bus.arb_error), 32'(exp_err));

      nxt_ihit = 1'b0;
      nxt_dhit = 1'b0;
      i_quiet  = 1'b0;
      d_quiet  = 1'b0;

      // requesters retire on their hit
      if (exp_ihit) i_pend = 1'b0;
      if (exp_dhit) d_pend = 1'b0;

      // occasional withdrawal while the RAM is being accessed
      if (strobing && !hold_busy && ($urandom_range(0, 24) == 0)) begin
         if (!t_we) begin
            if (t_src == SRC_I) begin
               i_pend  = 1'b0;
               i_quiet = 1'b1;
            end else begin
               d_pend  = 1'b0;
               d_quiet = 1'b1;
            end
         end else if (d_pend && !d_both) begin
            d_pend  = 1'b0;
            d_ghost = 1'b1;
         end
      end

      // new requests
      if (!i_pend && !i_quiet && ($urandom_range(0, 9) < 6)) begin
         i_pend = 1'b1;
         i_addr = word_t'($urandom_range(0, 63)) << 2;
      end
      if (!d_pend && !d_quiet && !d_ghost && ($urandom_range(0, 9) < 6)) begin
         r      = int'($urandom_range(0, 9));
         d_pend = 1'b1;
         d_we   = (r < 4);
         d_both = (r == 0);
         d_addr = 32'h100 + (word_t'($urandom_range(0, 63)) << 2);
         d_data = $urandom();
      end

      bus.imemREN   = i_pend;
      bus.imemaddr  = i_pend ? i_addr : word_t'($urandom());
      bus.dmemREN   = d_pend && (!d_we || d_both);
      bus.dmemWEN   = d_pend && d_we;
      bus.dmemaddr  = d_pend ? d_addr : word_t'($urandom());
      bus.dmemstore = d_pend ? d_data : word_t'($urandom());

      // grant decision when the arbiter is free this cycle
      if (!txn_active && (cyc == idle_cyc)) begin
         if (d_pend && !(i_pend && (starve == SLIM))) begin
            txn_active = 1'b1;
            t_src      = SRC_D;
            t_we       = d_we;
            t_addr     = d_addr;
            t_data     = d_data;
            if (i_pend && (starve < SLIM)) starve++;
         end else if (i_pend) begin
            txn_active = 1'b1;
            t_src      = SRC_I;
            t_we       = 1'b0;
            t_addr     = i_addr;
            t_data     = '0;
            starve     = 0;
         end
         if (txn_active) begin
            resume_cyc = cyc + 1;
            t_err      = 0;
            t_plan     = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
         end else begin
            idle_cyc = cyc + 1;
         end
      end

      // RAM response for an access in progress
      rs = ramstate_t'($urandom_range(0, 3));
      ld = $urandom();
      if (strobing) begin
         live = (t_src == SRC_I) ? i_pend : d_pend;
         idx  = int'(t_addr[8:2]);
         if (!t_we && !live) begin
            txn_active = 1'b0;
            idle_cyc   = cyc + 1;
            n_txn++;
            $display("txn %0d: %s read addr=%h withdrawn", n_txn, (t_src == SRC_I) ? "I" : "D", t_addr);
         end else if (hold_busy || ($urandom_range(0, 1) == 0)) begin
            rs = ($urandom_range(0, 1) == 0) ? BUSY : FREE;
         end else if (t_err < t_plan) begin
            rs = ERROR;
            if (t_err == MAXR) begin
               exp_err    = 1'b1;
               txn_active = 1'b0;
               idle_cyc   = cyc + 1;
               n_txn++;
               $display("txn %0d: %s addr=%h aborted after %0d errors", n_txn,
                        (t_src == SRC_I) ? "I" : "D", t_addr, t_err + 1);
            end else begin
               t_err++;
               resume_cyc = cyc + 2;
            end
         end else begin
            rs = ACCESS;
            n_txn++;
            if (!t_we) begin
               ld = mem[idx];
               if (t_src == SRC_I) begin
                  exp_iload = ld;
                  nxt_ihit  = 1'b1;
               end else begin
                  exp_dload = ld;
                  nxt_dhit  = 1'b1;
               end
               $display("txn %0d: %s read  addr=%h data=%h retries=%0d", n_txn,
                        (t_src == SRC_I) ? "I" : "D", t_addr, ld, t_err);
            end else begin
               mem[idx] = t_data;
               nxt_dhit = d_pend;
               d_ghost  = 1'b0;
               $display("txn %0d: D write addr=%h data=%h retries=%0d ack=%0d", n_txn,
                        t_addr, t_data, t_err, nxt_dhit);
            end
            txn_active = 1'b0;
            idle_cyc   = cyc + 2;
         end
      end

      bus.ramstate = rs;
      bus.ramload  = ld;
      exp_ihit     = nxt_ihit;
      exp_dhit     = nxt_dhit;
      cyc++;
   endtask

   initial begin
      bus.imemREN   = 1'b0;
      bus.imemaddr  = '0;
      bus.dmemREN   = 1'b0;
      bus.dmemWEN   = 1'b0;
      bus.dmemaddr  = '0;
      bus.dmemstore = '0;
      bus.ramload   = '0;
      bus.ramstate  = FREE;
      for (int i = 0; i < 128; i++) mem[i] = $urandom();
      i_pend = 0; d_pend = 0; d_we = 0; d_both = 0; d_ghost = 0;
      txn_active = 0; t_src = SRC_I; t_we = 0; t_addr = '0; t_data = '0;
      t_err = 0; t_plan = 0; resume_cyc = 0; idle_cyc = 0; starve = 0;
      exp_ihit = 0; exp_dhit = 0; exp_err = 0; exp_iload = '0; exp_dload = '0;

      // reset state
      repeat (3) @(negedge CLK);
      check_val("rst_ramREN", 32'(bus.ramREN), 32'd0);
      check_val("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
      check_val("rst_ihit", 32'(bus.ihit), 32'd0);
      check_val("rst_dhit", 32'(bus.dhit), 32'd0);
      check_val("rst_arb_error", 32'(bus.arb_error), 32'd0);
      check_val("rst_imemload", bus.imemload, 32'd0);
      check_val("rst_dmemload", bus.dmemload, 32'd0);
      check_val("rst_ramaddr", bus.ramaddr, 32'd0);
      nRST = 1'b1;

      // randomized traffic
      for (int k = 0; k < NCYC; k++) step_cycle(1'b0, stb);

      // reset in the middle of an access: strobes must fall immediately
      stb = 1'b0;
      for (int k = 0; (k < 100) && !stb; k++) step_cycle(1'b1, stb);
      check_val("reach_access", 32'(stb), 32'd1);
      #1 nRST = 1'b0;
      #1;
      check_val("async_ramREN", 32'(bus.ramREN), 32'd0);
      check_val("async_ramWEN", 32'(bus.ramWEN), 32'd0);
      check_val("async_ihit", 32'(bus.ihit), 32'd0);
      check_val("async_dhit", 32'(bus.dhit), 32'd0);
      check_val("async_arb_error", 32'(bus.arb_error), 32'd0);
      repeat (2) @(negedge CLK);
      check_val("rst2_ihit", 32'(bus.ihit), 32'd0);
      check_val("rst2_dhit", 32'(bus.dhit), 32'd0);
      check_val("rst2_imemload", bus.imemload, 32'd0);
      check_val("rst2_dmemload", bus.dmemload, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
